// File: rtl/seq_mult_unsigned.sv
// Iterative shift-and-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH), valid/ready on both sides.
// Optional early termination on exhausted multiplier bits: define MULT_EARLY_TERM_EN.
module seq_mult_unsigned #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_sh;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     b_sh;
  logic [CNT_W-1:0]     count;
  logic                 last_iter;

  assign acc_sum = acc + (b_sh[0] ? a_sh : '0);

`ifdef MULT_EARLY_TERM_EN
  // No set bits remain above the current one, so later adds would all be zero.
  assign last_iter = (b_sh[WIDTH-1:1] == '0);
`else
  assign last_iter = (count == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last_iter) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      count <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= {{WIDTH{1'b0}}, a};
            b_sh  <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_sum;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
          count <= count + CNT_W'(1);
          if (last_iter) p <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_unsigned.sv
// Scoreboard bench for seq_mult_unsigned: 32-bit main instance plus an 8-bit instance.
module tb_seq_mult_unsigned;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] p;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] sb[$];

  seq_mult_unsigned #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  seq_mult_unsigned #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int unsigned width, input logic [63:0] bb);
`ifdef MULT_EARLY_TERM_EN
    int l = 1;
    for (int i = 0; i < 64; i++)
      if (i < int'(width) && bb[i]) l = i + 1;
    return l;
`else
    return int'(width);
`endif
  endfunction

  // hold=0: out_ready held high throughout; hold>0: out_ready low for hold DONE cycles.
  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb, input int hold);
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    out_ready = (hold == 0);
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    a = aa; b = bb; in_valid = 1'b1;
    sb.push_back(64'(aa) * 64'(bb));
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    check("accept_busy", {62'd0, busy, in_ready}, 64'd2);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      // Junk requests while BUSY/DONE must never be captured.
      in_valid = hold > 0;
      a = $urandom; b = $urandom;
    end
    check("latency", 64'(lat), 64'(exp_lat(32, 64'(bb))));
    check("done_flags", {62'd0, busy, out_valid}, 64'd1);
    exp = (sb.size() > 0) ? sb[0] : 64'd0;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_p", p, exp);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("product", p, (sb.size() > 0) ? sb.pop_front() : 64'hDEAD);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {62'd0, out_valid, in_ready}, 64'd1);
    check("p_kept", p, exp);
  endtask

  initial begin
    int lat8;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_p", p, 64'd0);
    check("rst_flags", {61'd0, out_valid, busy, in_ready}, 64'd1);

    do_op(32'd12, 32'd4, 5);
    do_op(32'd3, 32'd4, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    // Abort mid-operation after 10 BUSY edges.
    @(negedge clk);
    a = 32'd20; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_p", p, 64'd0);
    check("abort_flags", {61'd0, out_valid, busy, in_ready}, 64'd1);
    repeat (40) @(negedge clk);
    check("abort_no_result", {63'd0, out_valid}, 64'd0);

    do_op(32'd7, 32'd6, 2);
    do_op(32'd0, 32'd5, 0);
    do_op(32'd9, 32'd0, 0);
    do_op(32'd1, 32'h8000_0000, 0);
    for (int i = 0; i < 4; i++) do_op($urandom, $urandom, i);

    // 8-bit instance
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat8 = 0;
    while (!out_valid8 && lat8 < 100) begin
      @(negedge clk);
      lat8++;
    end
    check("w8_latency", 64'(lat8), 64'(exp_lat(8, 64'hFF)));
    check("w8_product", 64'(p8), 64'hFE01);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("w8_release", {62'd0, out_valid8, in_ready8}, 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
